// File: rtl/sync_fifo_reader.sv
// Read-side master for sync_fifo: pops words through the FIFO read port and re-presents them on a
// valid/ready stream, using a head/skid buffer to hide the FIFO's registered read latency.
module sync_fifo_reader #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_rd_en,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  input  logic             flush,
  output logic             busy,
  output logic [CNT_W-1:0] words_out
);

  logic [1:0]       cnt_q, cnt_d;
  logic [1:0]       occ;
  logic [1:0]       after_pop;
  logic             pend_q, pend_d;
  logic             valid_q, valid_d;
  logic             pop;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [CNT_W-1:0] words_q, words_d;

  always_comb begin
    pop = valid_q && m_ready;
    occ = cnt_q + {1'b0, pend_q};

    // A read is allowed whenever the word it returns is guaranteed a buffer slot next cycle.
    fifo_rd_en = rst && !flush && !fifo_empty &&
                 ((occ < 2'd2) || ((occ == 2'd2) && pop));

    after_pop = cnt_q - {1'b0, pop};
    head_d    = head_q;
    skid_d    = skid_q;
    if (pop && (cnt_q == 2'd2)) begin
      head_d = skid_q;
    end
    if (pend_q) begin
      if (after_pop == 2'd0) begin
        head_d = fifo_data;
      end else begin
        skid_d = fifo_data;
      end
    end

    cnt_d  = after_pop + {1'b0, pend_q};
    pend_d = fifo_rd_en && !fifo_empty;
    if (flush) begin
      cnt_d  = 2'd0;
      pend_d = 1'b0;
    end

    valid_d = (cnt_d != 2'd0);
    words_d = words_q + CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= 2'd0;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      head_q  <= '0;
      skid_q  <= '0;
      words_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      words_q <= words_d;
    end
  end

  assign m_valid   = valid_q;
  assign m_data    = head_q;
  assign busy      = (cnt_q != 2'd0) || pend_q;
  assign words_out = words_q;

endmodule
